des_stream_mode: RTL

//  Streaming mode controller placed in front of the pipelined des_top core.
//  - Adds valid/ready handshakes on both the input and output sides.
//  - Drives the core's key load and waits for its subkeys before accepting data.
//  - Chains blocks in ECB or CBC mode.
//  - Credit-limits issue into the non-stallable core pipeline, so results land in an output FIFO that can absorb back-pressure.

---
 rtl/des_stream_mode.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/des_stream_mode.sv
// Streaming valid/ready mode controller in front of the pipelined des_top core.
// Define DES_CBC_EN to build CBC chaining; without it the block is ECB-only.
module des_stream_mode #(
    parameter int FIFO_DEPTH  = 32,
    parameter int KEY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        cfg_encrypt,
    input  logic        cfg_cbc,
    input  logic [63:0] cfg_key,
    input  logic [63:0] cfg_iv,
    output logic        cfg_busy,
    output logic        key_err,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        m_last,
    output logic        core_encrypt,
    output logic [63:0] core_key,
    output logic        core_key_load,
    input  logic        core_keys_valid,
    output logic        core_din_en,
    output logic [63:0] core_din,
    input  logic [63:0] core_dout,
    input  logic        core_dout_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(KEY_TIMEOUT + 1);
    localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(KEY_TIMEOUT - 1);
`ifdef DES_CBC_EN
    localparam int SW = 65;
`else
    localparam int SW = 1;
`endif

    typedef enum logic [1:0] {NOKEY, LOAD, WAIT, RUN} state_t;
    state_t state_q, state_d;

    logic [TW-1:0] tmo_q;
    logic [CW-1:0] inflight_q, ocount_q;
    logic          enc_q;
    logic [63:0]   key_q;
    logic          accept_cfg, fire, retire, pop, timeout, cbc_enc_wait;
    logic [63:0]   in_mask, side_mask;
    logic [SW-1:0] side_wdata, side_rdata;
    logic          side_last;

    logic [SW-1:0] side_mem [FIFO_DEPTH];
    logic [AW-1:0] side_wp, side_rp;
    logic [64:0]   out_mem [FIFO_DEPTH];
    logic [AW-1:0] out_wp, out_rp;

    assign accept_cfg = cfg_start && !cfg_busy;
    assign fire       = s_valid && s_ready;
    // Pulses with nothing in flight are leftovers from before a reset.
    assign retire     = core_dout_valid && (inflight_q != '0);
    assign pop        = m_valid && m_ready;
    assign side_rdata = side_mem[side_rp];
    assign side_last  = side_rdata[0];

`ifdef DES_CBC_EN
    logic        cbc_q;
    logic [63:0] iv_q, chain_q;

    assign cbc_enc_wait = cbc_q && enc_q && (inflight_q != '0);
    assign in_mask      = (cbc_q && enc_q) ? chain_q : 64'h0;
    assign side_wdata   = {(cbc_q && !enc_q) ? chain_q : 64'h0, s_last};
    assign side_mask    = side_rdata[64:1];

    // Encrypt chains on the core result; decrypt chains on the ciphertext going in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbc_q   <= 1'b0;
            iv_q    <= '0;
            chain_q <= '0;
        end else if (accept_cfg) begin
            cbc_q   <= cfg_cbc;
            iv_q    <= cfg_iv;
            chain_q <= cfg_iv;
        end else if (cbc_q && !enc_q && fire) begin
            chain_q <= s_last ? iv_q : s_data;
        end else if (cbc_q && enc_q && retire) begin
            chain_q <= side_last ? iv_q : core_dout;
        end
    end
`else
    logic unused_cfg;
    assign cbc_enc_wait = 1'b0;
    assign in_mask      = '0;
    assign side_wdata   = s_last;
    assign side_mask    = '0;
    assign unused_cfg   = ^{cfg_cbc, cfg_iv};
`endif

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            NOKEY: if (accept_cfg) state_d = LOAD;
            LOAD:  state_d = WAIT;
            WAIT: begin
                if (core_keys_valid) state_d = RUN;
                else if (tmo_q == TMO_LAST) begin
                    timeout = 1'b1;
                    state_d = NOKEY;
                end
            end
            RUN:   if (accept_cfg) state_d = LOAD;
            default: state_d = NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NOKEY;
            tmo_q   <= '0;
            key_err <= 1'b0;
            enc_q   <= 1'b0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
            if (accept_cfg) begin
                key_err <= 1'b0;
                enc_q   <= cfg_encrypt;
                key_q   <= cfg_key;
            end else if (timeout) begin
                key_err <= 1'b1;
            end
        end
    end

    // Credits cover both the core pipeline and the output FIFO, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            ocount_q   <= '0;
            side_wp    <= '0;
            side_rp    <= '0;
            out_wp     <= '0;
            out_rp     <= '0;
        end else begin
            case ({fire, retire})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
            case ({retire, pop})
                2'b10:   ocount_q <= ocount_q + 1'b1;
                2'b01:   ocount_q <= ocount_q - 1'b1;
                default: ocount_q <= ocount_q;
            endcase
            if (fire)   side_wp <= side_wp + 1'b1;
            if (retire) side_rp <= side_rp + 1'b1;
            if (retire) out_wp  <= out_wp + 1'b1;
            if (pop)    out_rp  <= out_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire)   side_mem[side_wp] <= side_wdata;
        if (retire) out_mem[out_wp]   <= {core_dout ^ side_mask, side_last};
    end

    assign cfg_busy      = (state_q == LOAD) || (state_q == WAIT) ||
                           (inflight_q != '0) || (ocount_q != '0);
    assign s_ready       = (state_q == RUN) && !cbc_enc_wait &&
                           (({1'b0, inflight_q} + {1'b0, ocount_q}) < CREDITS);
    assign core_din_en   = fire;
    assign core_din      = fire ? (s_data ^ in_mask) : 64'h0;
    assign core_key_load = (state_q == LOAD);
    assign core_key      = key_q;
    assign core_encrypt  = enc_q;
    assign m_valid       = (ocount_q != '0);
    assign {m_data, m_last} = m_valid ? out_mem[out_rp] : 65'h0;
endmodule
